// File: rtl/div_pkg.sv
// Shared constants, ratio type and high-phase helper for the multi-channel clock divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT    = 8;
    localparam int DIV_CHANNELS_DEFAULT = 2;

    typedef logic [DIV_WIDTH_DEFAULT-1:0] div_ratio_t;

    // High-phase length ceil(r/2); odd ratios get the extra cycle in the high phase.
    function automatic logic [31:0] div_high_len(input logic [31:0] r);
        return (r >> 1) + {31'b0, r[0]};
    endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: period counter, active ratio latched at period boundaries,
// registered near-50% waveform and end-of-period tick.
module div_channel
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             force_load,
    input  logic [WIDTH-1:0] div,
    output logic             q,
    output logic             tick
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] r_act;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] h;
    logic             load;
    logic             q_nxt;
    logic             tick_nxt;

    assign h = WIDTH'(div_high_len(32'(r_act)));

    // Ratios 0 and 1 reload every cycle, so div is re-sampled continuously for them.
    always_comb begin
        load     = force_load || (r_act[WIDTH-1:1] == '0) || (cnt == r_act - ONE);
        r_nxt    = r_act;
        cnt_nxt  = cnt + ONE;
        q_nxt    = 1'b0;
        tick_nxt = 1'b0;
        if (load) begin
            r_nxt   = div;
            cnt_nxt = '0;
            q_nxt   = (div != '0);
        end else begin
            q_nxt   = (cnt_nxt < h);
        end
        tick_nxt = (r_nxt != '0) && (cnt_nxt == r_nxt - ONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            r_act <= '0;
            q     <= 1'b0;
            tick  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            r_act <= r_nxt;
            q     <= q_nxt;
            tick  <= tick_nxt;
        end
    end

endmodule

// File: rtl/div_multi.sv
// CHANNELS independent glitch-free clock-enable dividers sharing one clock.
// Define DIV_SYNC_EN to add the sync input that phase-restarts every channel.
module div_multi
    import div_pkg::*;
#(
    parameter int WIDTH    = DIV_WIDTH_DEFAULT,
    parameter int CHANNELS = DIV_CHANNELS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] div,
`ifdef DIV_SYNC_EN
    input  logic                      sync,
`endif
    output logic [CHANNELS-1:0]       q,
    output logic [CHANNELS-1:0]       tick
);

    logic force_load;

`ifdef DIV_SYNC_EN
    assign force_load = sync;
`else
    assign force_load = 1'b0;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        div_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .force_load (force_load),
            .div        (div[c*WIDTH +: WIDTH]),
            .q          (q[c]),
            .tick       (tick[c])
        );
    end

endmodule

// File: tb/tb_div_multi.sv
// Directed bench for div_multi (WIDTH=8, CHANNELS=2) with hand-written waveform patterns.
module tb_div_multi;

    localparam int W = 8;
    localparam int C = 2;

    logic           clk;
    logic           reset_n;
    logic [C*W-1:0] div;
    logic           sync;
    logic [C-1:0]   q;
    logic [C-1:0]   tick;

    int n_tests;
    int n_fail;

    logic [3:0] exp_q[$];

    div_multi #(
        .WIDTH    (W),
        .CHANNELS (C)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div     (div),
`ifdef DIV_SYNC_EN
        .sync    (sync),
`endif
        .q       (q),
        .tick    (tick)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sampled view: {q1, tick1, q0, tick0}
    function automatic logic [3:0] obs();
        return {q[1], tick[1], q[0], tick[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one rising edge, then settle before sampling or driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input logic [W-1:0] d0, input logic [W-1:0] d1);
        div = {d1, d0};
    endtask

    // patterns are MSB-first: bit n-1 is the first edge after the call
    task automatic expect_seq(input string tag, input int n,
                              input logic [63:0] q0, input logic [63:0] t0,
                              input logic [63:0] q1, input logic [63:0] t1);
        logic [3:0] e;
        for (int i = 0; i < n; i++)
            exp_q.push_back({q1[n-1-i], t1[n-1-i], q0[n-1-i], t0[n-1-i]});
        for (int i = 0; i < n; i++) begin
            step();
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i), {28'b0, obs()}, {28'b0, e});
        end
    endtask

    initial begin
        logic [3:0] e;
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        sync    = 1'b0;
        div     = '0;
        repeat (3) step();
        check("reset_q", {30'b0, q}, 32'h0);
        check("reset_tick", {30'b0, tick}, 32'h0);

        // ratio 3 on ch0, ch1 disabled
        set_div(8'd3, 8'd0);
        reset_n = 1'b1;
        expect_seq("r3", 21, 21'b110110110110110110110, 21'b001001001001001001001,
                   64'h0, 64'h0);

        // ratios 4 and 5 side by side
        set_div(8'd4, 8'd5);
        expect_seq("r4r5", 20, 20'b11001100110011001100, 20'b00010001000100010001,
                   20'b11100111001110011100, 20'b00001000010000100001);

        // 6 -> 2 change at cnt=1: the 6-cycle period must finish intact
        set_div(8'd6, 8'd0);
        expect_seq("r6a", 2, 2'b11, 2'b00, 64'h0, 64'h0);
        set_div(8'd2, 8'd0);
        expect_seq("r6to2", 10, 10'b1000101010, 10'b0001010101, 64'h0, 64'h0);

        // ratio 0 idle, ratio 1 constant high with tick every cycle
        set_div(8'd0, 8'd1);
        expect_seq("r0r1", 6, 64'h0, 64'h0, 6'b111111, 6'b111111);
        set_div(8'd3, 8'd1);
        expect_seq("r0to3", 6, 6'b110110, 6'b001001, 6'b111111, 6'b111111);

        // maximum ratio: 128 high, 127 low, tick on cycle 254, then a fresh period
        set_div(8'd255, 8'd0);
        for (int i = 0; i < 256; i++) begin
            e = {2'b00, (i < 128 || i == 255), (i == 254)};
            step();
            check($sformatf("r255[%0d]", i), {28'b0, obs()}, {28'b0, e});
        end

        // reset asserted mid-period at cnt=2 of ratio 5
        reset_n = 1'b0;
        step();
        check("rst_clear", {28'b0, obs()}, 32'h0);
        set_div(8'd5, 8'd3);
        reset_n = 1'b1;
        expect_seq("pre_rst", 3, 3'b111, 3'b000, 3'b110, 3'b001);
        reset_n = 1'b0;
        step();
        check("rst_mid", {28'b0, obs()}, 32'h0);
        reset_n = 1'b1;
        expect_seq("post_rst", 10, 10'b1110011100, 10'b0000100001,
                   10'b1101101101, 10'b0010010010);

`ifdef DIV_SYNC_EN
        // ch0 at cnt=2, ch1 at cnt=0 when sync hits
        expect_seq("pre_sync", 3, 3'b111, 3'b000, 3'b101, 3'b010);
        sync = 1'b1;
        step();
        check("sync_edge", {28'b0, obs()}, {28'b0, 4'b1010});
        sync = 1'b0;
        expect_seq("post_sync", 6, 6'b110011, 6'b000100, 6'b101101, 6'b010010);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
